float_norm_pack: RTL and testbench

FLOAT_NORM_PACK -- requirements
Module: float_norm_pack

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/float_norm_pack_lzc24.sv | 23 ++
 rtl/float_norm_pack.sv | 187 ++++++++++++++++++
 tb/tb_float_norm_pack.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg -- constants and types shared by the FPU datapath blocks.
//   EXP_W / FRAC_W / RAW_W : IEEE-754 single field widths and the raw
//                            magnitude width {carry, hidden, frac}.
//   EXP_MAX                : all-ones exponent (infinity / NaN).
//   fnormState_t           : float_norm_pack control states.
//   faluOp_t               : FALU operation encodings used across the FPU.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int RAW_W  = 25;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } fnormState_t;

  typedef enum logic [2:0] {
    FALU_ADD = 3'd0,
    FALU_SUB = 3'd1,
    FALU_MUL = 3'd2,
    FALU_DIV = 3'd3,
    FALU_CMP = 3'd4
  } faluOp_t;

endpackage

// File: rtl/float_norm_pack_lzc24.sv
// lzc24 -- combinational 24-bit leading-zero counter.
//   value : 24-bit input word.
//   count : number of zero bits above the most significant one (24 if zero).
module lzc24 (
  input  logic [23:0] value,
  output logic [4:0]  count
);

  logic found;

  // Scan from the MSB; the first one seen fixes the count.
  always_comb begin
    count = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = 5'(23 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/float_norm_pack.sv
// float_norm_pack -- normalizes a raw mantissa/exponent pair coming out of
// the add/sub/mul stage and packs it into an IEEE-754 single word.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset.
//   in_valid/in_ready : operand handshake; transfer on a rising edge where
//                       both are high. out_valid/out_ready: result handshake,
//                       transfer on a rising edge where both are high. A
//                       valid result is held stable until it is taken.
//   in_sign, in_exp   : sign and biased exponent of the raw operand.
//   in_frac           : raw magnitude {carry, hidden, frac[22:0]}.
//   result            : packed {sign, exp[7:0], frac[22:0]}.
//   flag_zero/ovf/unf : zero result / overflow to infinity / subnormal result.
//   dbgState          : current control state, for observation.
//
// Build option: define FNORM_LZC_EN to normalize in a single cycle with a
// leading-zero counter; otherwise the mantissa is shifted one bit per cycle.
// Both builds produce identical results. Rounding is not performed.
module float_norm_pack
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [RAW_W-1:0]  in_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              flag_zero,
  output logic              flag_ovf,
  output logic              flag_unf,
  output fnormState_t       dbgState
);

  fnormState_t state, stateNext;

  logic             workSign;
  logic [EXP_W-1:0] workExp;
  logic [RAW_W-1:0] workFrac;

  logic [31:0]      resultReg;
  logic             zeroReg, ovfReg, unfReg;

  // NORM-cycle datapath
  logic             normDone;
  logic [EXP_W-1:0] carryExp;
  logic [EXP_W-1:0] shExp;
  logic [RAW_W-1:0] shFrac;
  logic [31:0]      packRes;
  logic             packZero, packOvf, packUnf;

`ifdef FNORM_LZC_EN
  logic [4:0]       lzCount;
  logic [EXP_W-1:0] maxShift;
  logic [EXP_W-1:0] shAmt;

  lzc24 uLzc (
    .value (workFrac[23:0]),
    .count (lzCount)
  );
`endif

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:  if (in_valid)  stateNext = S_NORM;
      S_NORM:  if (normDone)  stateNext = S_DONE;
      S_DONE:  if (out_ready) stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    dbgState  = state;
  end

  // ------------------------------------------------------ normalize / pack
  always_comb begin
    normDone = 1'b0;
    carryExp = workExp + 8'd1;
    shExp    = workExp;
    shFrac   = workFrac;
    packRes  = 32'h0;
    packZero = 1'b0;
    packOvf  = 1'b0;
    packUnf  = 1'b0;
`ifdef FNORM_LZC_EN
    maxShift = 8'd0;
    shAmt    = 8'd0;
`endif

    if (workFrac == '0) begin
      normDone = 1'b1;
      packRes  = {workSign, 31'b0};
      packZero = 1'b1;
    end else if (workFrac[24]) begin
      // Carry out of the mantissa: one right shift always suffices.
      normDone = 1'b1;
      if (carryExp == EXP_MAX) begin
        packRes = {workSign, EXP_MAX, 23'b0};
        packOvf = 1'b1;
      end else begin
        packRes = {workSign, carryExp, workFrac[23:1]};
      end
    end else begin
`ifdef FNORM_LZC_EN
      // Shift the whole way at once, but never let exp drop below 1;
      // whatever is left un-normalized then packs as a subnormal.
      if (workExp > 8'd1) begin
        maxShift = workExp - 8'd1;
        if ({3'b0, lzCount} < maxShift) shAmt = {3'b0, lzCount};
        else                            shAmt = maxShift;
      end
      shFrac   = workFrac << shAmt;
      shExp    = workExp - shAmt;
      normDone = 1'b1;
`else
      if (!workFrac[23] && (workExp > 8'd1)) begin
        shFrac = workFrac << 1;
        shExp  = workExp - 8'd1;
      end else begin
        normDone = 1'b1;
      end
`endif
      if (shFrac[23]) begin
        packRes = {workSign, shExp, shFrac[22:0]};
      end else begin
        packRes = {workSign, 8'h00, shFrac[22:0]};
        packUnf = 1'b1;
      end
    end
  end

  // ------------------------------------------------------ working registers
  always_ff @(posedge clk) begin
    if (rst) begin
      workSign  <= 1'b0;
      workExp   <= '0;
      workFrac  <= '0;
      resultReg <= 32'h0;
      zeroReg   <= 1'b0;
      ovfReg    <= 1'b0;
      unfReg    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            workSign <= in_sign;
            workExp  <= in_exp;
            workFrac <= in_frac;
            zeroReg  <= 1'b0;
            ovfReg   <= 1'b0;
            unfReg   <= 1'b0;
          end
        end
        S_NORM: begin
          workExp  <= shExp;
          workFrac <= shFrac;
          if (normDone) begin
            resultReg <= packRes;
            zeroReg   <= packZero;
            ovfReg    <= packOvf;
            unfReg    <= packUnf;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = resultReg;
  assign flag_zero = zeroReg;
  assign flag_ovf  = ovfReg;
  assign flag_unf  = unfReg;

endmodule

// File: tb/tb_float_norm_pack.sv
module tb_float_norm_pack;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_frac;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_zero, flag_ovf, flag_unf;
  fnormState_t dbgState;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] expQ[$];

  // ------------------------------------------------------ clock / reset
  always #5 clk = ~clk;

  float_norm_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_frac   (in_frac),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_zero (flag_zero),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .dbgState  (dbgState)
  );

  // ------------------------------------------------------ checking
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: value-level normalization on integers.
  function automatic void refNorm(input logic s, input int e, input longint f,
                                  output logic [31:0] res, output logic [2:0] flags,
                                  output int shifts);
    int     ex;
    longint m;
    res = 32'h0; flags = 3'b000; shifts = 0; ex = e; m = f;
    if (m == 0) begin
      res = {s, 31'b0};
      flags = 3'b100;
    end else if (m >= (64'd1 << 24)) begin
      ex = (e + 1) % 256;
      m  = m / 2;
      if (ex == 255) begin
        res = {s, 8'hFF, 23'b0};
        flags = 3'b010;
      end else begin
        res = {s, 8'(ex), 23'(m % (64'd1 << 23))};
      end
    end else begin
      while (m < (64'd1 << 23) && ex > 1) begin
        m = m * 2;
        ex--;
        shifts++;
      end
      if (m >= (64'd1 << 23)) res = {s, 8'(ex), 23'(m - (64'd1 << 23))};
      else begin
        res = {s, 8'h00, 23'(m)};
        flags = 3'b001;
      end
    end
  endfunction

  // ------------------------------------------------------ driver
  // Called #1 after a rising edge with the DUT idle.
  task automatic runOp(input logic s, input logic [7:0] e, input logic [24:0] f, input int hold);
    logic [31:0] want;
    logic [2:0]  wantFlags;
    int          shifts, wantLat, lat;
    logic [31:0] held;
    refNorm(s, int'(e), longint'(f), want, wantFlags, shifts);
`ifdef FNORM_LZC_EN
    wantLat = 1;
`else
    wantLat = shifts + 1;
`endif
    expQ.push_back(want);
    checkVal("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_frac = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checkVal("out_valid_timeout", 32'(out_valid), 32'd1);
      void'(expQ.pop_front());
      return;
    end
    checkVal("latency", 32'(lat), 32'(wantLat));
    checkVal("result", result, expQ.pop_front());
    checkVal("flags", 32'({flag_zero, flag_ovf, flag_unf}), 32'(wantFlags));
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkVal("hold_valid", 32'(out_valid), 32'd1);
      checkVal("hold_result", result, held);
      checkVal("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal("handoff_valid", 32'(out_valid), 32'd0);
    checkVal("handoff_in_ready", 32'(in_ready), 32'd1);
  endtask

  // ------------------------------------------------------ stimulus
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_frac = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkVal("reset_in_ready", 32'(in_ready), 32'd1);
    checkVal("reset_out_valid", 32'(out_valid), 32'd0);
    checkVal("reset_result", result, 32'h0);
    checkVal("reset_flags", 32'({flag_zero, flag_ovf, flag_unf}), 32'd0);
    checkVal("reset_state", 32'(dbgState), 32'(S_IDLE));

    // Directed cases with hand-derived results
    runOp(1'b0, 8'd130, 25'h0800000, 0);
    checkVal("dir_8p0", result, 32'h41000000);
    runOp(1'b0, 8'd127, 25'h1800000, 1);
    checkVal("dir_3p0", result, 32'h40400000);
    runOp(1'b0, 8'd130, 25'h0100000, 0);
    checkVal("dir_1p0", result, 32'h3F800000);
    runOp(1'b1, 8'd77, 25'h0000000, 0);
    checkVal("dir_negzero", result, 32'h80000000);
    checkVal("dir_zero_flag", 32'(flag_zero), 32'd1);
    runOp(1'b0, 8'd254, 25'h1000000, 0);
    checkVal("dir_inf", result, 32'h7F800000);
    checkVal("dir_ovf_flag", 32'(flag_ovf), 32'd1);
    runOp(1'b0, 8'd2, 25'h0000001, 5);
    checkVal("dir_subn", result, 32'h00000002);
    checkVal("dir_unf_flag", 32'(flag_unf), 32'd1);
    runOp(1'b0, 8'd1, 25'h0400000, 0);
    runOp(1'b1, 8'd24, 25'h0000001, 0);

    // Reset while normalizing: the operand is dropped
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd130; in_frac = 25'h0100000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkVal("midrst_out_valid", 32'(out_valid), 32'd0);
    checkVal("midrst_result", result, 32'h0);
    checkVal("midrst_in_ready", 32'(in_ready), 32'd1);
    runOp(1'b0, 8'd130, 25'h0100000, 0);
    checkVal("midrst_next", result, 32'h3F800000);

    // Random operands
    for (int n = 0; n < 200; n++) begin
      logic [24:0] f;
      logic [7:0]  e;
      case ($urandom_range(0, 9))
        0:       f = 25'h0;
        1, 2:    f = 25'h1000000 | 25'($urandom);
        default: f = 25'(($urandom & 32'h0FFFFFF) >> $urandom_range(0, 24));
      endcase
      e = 8'($urandom_range(0, 254));
      if ($urandom_range(0, 4) == 0) e = 8'($urandom_range(0, 3));
      runOp(1'($urandom), e, f, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
